// File: rtl/alu_pkg.sv
// Shared opcode, flag-index and FSM definitions for the ALU sharing controller
// and its round-robin arbiter.
package alu_pkg;

    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_SUB  = 5'b00001;
    localparam logic [4:0] OP_AND  = 5'b00010;
    localparam logic [4:0] OP_OR   = 5'b00011;
    localparam logic [4:0] OP_SLL  = 5'b00100;
    localparam logic [4:0] OP_SRA  = 5'b00101;
    localparam logic [4:0] OP_NOT  = 5'b00110;
    localparam logic [4:0] OP_LAST = 5'b00110;

    localparam int unsigned FLG_NE  = 0;
    localparam int unsigned FLG_LT  = 1;
    localparam int unsigned FLG_OVF = 2;
    localparam int unsigned FLG_ERR = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_e;

    function automatic logic op_is_legal(input logic [4:0] op);
        return op <= OP_LAST;
    endfunction

endpackage

// File: rtl/alu_rr_arb2.sv
// Two-way round-robin grant: a lone requester always wins, a tie goes to prio.
module alu_rr_arb2 (
    input  logic [1:0] valid,
    input  logic       prio,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (valid == 2'b11) begin
            grant = prio ? 2'b10 : 2'b01;
        end else begin
            grant = valid;
        end
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one ALU between two requesters: arbitrates, issues registered operands,
// waits the fixed ALU latency and returns the captured result to the owner.
module alu_share_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned ALU_LAT = 1,
    parameter int unsigned WIDTH   = 32
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    input  logic [9:0]           req_opcode,
    input  logic [2*WIDTH-1:0]   req_a,
    input  logic [2*WIDTH-1:0]   req_b,
    input  logic [9:0]           req_shamt,
    output logic [4:0]           alu_opcode,
    output logic [WIDTH-1:0]     alu_a,
    output logic [WIDTH-1:0]     alu_b,
    output logic [4:0]           alu_shamt,
    input  logic [WIDTH-1:0]     alu_result,
    input  logic                 alu_ne,
    input  logic                 alu_lt,
    input  logic                 alu_ovf,
    output logic [1:0]           rsp_valid,
    input  logic [1:0]           rsp_ready,
    output logic [WIDTH-1:0]     rsp_result,
    output logic [3:0]           rsp_flags,
    output logic                 busy
);

    state_e           state_q, state_d;
    logic             prio_q, prio_d;
    logic             owner_q, owner_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [4:0]       alu_opcode_q, alu_opcode_d;
    logic [4:0]       alu_shamt_q, alu_shamt_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
    logic [3:0]       rsp_flags_q, rsp_flags_d;

    logic [1:0]       grant;
    logic             sel;
    logic [4:0]       sel_opcode, sel_shamt;
    logic [WIDTH-1:0] sel_a, sel_b;

    alu_rr_arb2 u_arb (
        .valid (req_valid),
        .prio  (prio_q),
        .grant (grant)
    );

    assign sel        = grant[1];
    assign sel_opcode = sel ? req_opcode[9:5] : req_opcode[4:0];
    assign sel_shamt  = sel ? req_shamt[9:5]  : req_shamt[4:0];
    assign sel_a      = sel ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
    assign sel_b      = sel ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];

    always_comb begin
        state_d      = state_q;
        prio_d       = prio_q;
        owner_d      = owner_q;
        cnt_d        = cnt_q;
        alu_opcode_d = alu_opcode_q;
        alu_shamt_d  = alu_shamt_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        rsp_result_d = rsp_result_q;
        rsp_flags_d  = rsp_flags_q;
        req_ready    = 2'b00;
        rsp_valid    = 2'b00;

        case (state_q)
            ST_IDLE: begin
                // Gated so no grant is visible while reset is held.
                req_ready = grant & {2{reset_n}};
                if (grant != 2'b00) begin
                    owner_d = sel;
                    if (op_is_legal(sel_opcode)) begin
                        alu_opcode_d = sel_opcode;
                        alu_shamt_d  = sel_shamt;
                        alu_a_d      = sel_a;
                        alu_b_d      = sel_b;
                        cnt_d        = 4'(ALU_LAT);
                        state_d      = ST_EXEC;
                    end else begin
                        rsp_result_d          = '0;
                        rsp_flags_d           = '0;
                        rsp_flags_d[FLG_ERR]  = 1'b1;
                        state_d               = ST_RESP;
                    end
                end
            end
            ST_EXEC: begin
                if (cnt_q == 4'd1) begin
                    rsp_result_d         = alu_result;
                    rsp_flags_d          = '0;
                    rsp_flags_d[FLG_NE]  = alu_ne;
                    rsp_flags_d[FLG_LT]  = alu_lt;
                    rsp_flags_d[FLG_OVF] = alu_ovf;
                    state_d              = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                rsp_valid = owner_q ? 2'b10 : 2'b01;
                if (rsp_ready[owner_q]) begin
                    prio_d  = ~owner_q;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            prio_q       <= 1'b0;
            owner_q      <= 1'b0;
            cnt_q        <= '0;
            alu_opcode_q <= '0;
            alu_shamt_q  <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
        end else begin
            state_q      <= state_d;
            prio_q       <= prio_d;
            owner_q      <= owner_d;
            cnt_q        <= cnt_d;
            alu_opcode_q <= alu_opcode_d;
            alu_shamt_q  <= alu_shamt_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            rsp_result_q <= rsp_result_d;
            rsp_flags_q  <= rsp_flags_d;
        end
    end

    assign alu_opcode = alu_opcode_q;
    assign alu_shamt  = alu_shamt_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign rsp_result = rsp_result_q;
    assign rsp_flags  = rsp_flags_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: two instances (ALU_LAT 1 and 3), a pipelined ALU
// stand-in, a cycle-numbered transaction model, directed cases and random traffic.
module tb_alu_share_ctrl;
    import alu_pkg::*;

    logic clock   = 1'b0;
    logic reset_n = 1'b1;
    always #5 clock = ~clock;

    logic [1:0]  req_valid  [2];
    logic [1:0]  req_ready  [2];
    logic [9:0]  req_opcode [2];
    logic [63:0] req_a      [2];
    logic [63:0] req_b      [2];
    logic [9:0]  req_shamt  [2];
    logic [4:0]  alu_opcode [2];
    logic [31:0] alu_a      [2];
    logic [31:0] alu_b      [2];
    logic [4:0]  alu_shamt  [2];
    logic [31:0] alu_result [2];
    logic        alu_ne     [2];
    logic        alu_lt     [2];
    logic        alu_ovf    [2];
    logic [1:0]  rsp_valid  [2];
    logic [1:0]  rsp_ready  [2];
    logic [31:0] rsp_result [2];
    logic [3:0]  rsp_flags  [2];
    logic        busy       [2];

    int checks = 0;
    int errors = 0;

    // Golden ALU: {ovf, lt, ne, result}; compare flags only come from SUB.
    function automatic logic [34:0] alu_f(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [4:0] sh);
        logic [31:0] res;
        logic ne, lt, ovf;
        res = '0; ne = 1'b0; lt = 1'b0; ovf = 1'b0;
        case (op)
            OP_ADD: begin res = a + b; ovf = (a[31] == b[31]) && (res[31] != a[31]); end
            OP_SUB: begin
                res = a - b;
                ovf = (a[31] != b[31]) && (res[31] != a[31]);
                ne  = (a != b);
                lt  = ($signed(a) < $signed(b));
            end
            OP_AND: res = a & b;
            OP_OR:  res = a | b;
            OP_SLL: res = a << sh;
            OP_SRA: res = 32'($signed(a) >>> sh);
            OP_NOT: res = ~a;
            default: res = '0;
        endcase
        return {ovf, lt, ne, res};
    endfunction

    function automatic int lat_of(input int g);
        return (g == 0) ? 1 : 3;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int unsigned LAT = (g == 0) ? 1 : 3;
        logic [34:0] now_v, out_v;

        alu_share_ctrl #(.ALU_LAT(LAT), .WIDTH(32)) u_dut (
            .clock      (clock),
            .reset_n    (reset_n),
            .req_valid  (req_valid[g]),
            .req_ready  (req_ready[g]),
            .req_opcode (req_opcode[g]),
            .req_a      (req_a[g]),
            .req_b      (req_b[g]),
            .req_shamt  (req_shamt[g]),
            .alu_opcode (alu_opcode[g]),
            .alu_a      (alu_a[g]),
            .alu_b      (alu_b[g]),
            .alu_shamt  (alu_shamt[g]),
            .alu_result (alu_result[g]),
            .alu_ne     (alu_ne[g]),
            .alu_lt     (alu_lt[g]),
            .alu_ovf    (alu_ovf[g]),
            .rsp_valid  (rsp_valid[g]),
            .rsp_ready  (rsp_ready[g]),
            .rsp_result (rsp_result[g]),
            .rsp_flags  (rsp_flags[g]),
            .busy       (busy[g])
        );

        assign now_v = alu_f(alu_opcode[g], alu_a[g], alu_b[g], alu_shamt[g]);
        // Result only becomes correct LAT cycles after the operands are registered.
        if (LAT == 1) begin : g_l1
            assign out_v = now_v;
        end else begin : g_ln
            logic [34:0] pipe [LAT-1];
            always @(posedge clock) begin
                pipe[0] <= now_v;
                for (int k = 1; k < LAT - 1; k++) pipe[k] <= pipe[k-1];
            end
            assign out_v = pipe[LAT-2];
        end
        assign alu_result[g] = out_v[31:0];
        assign alu_ne[g]     = out_v[32];
        assign alu_lt[g]     = out_v[33];
        assign alu_ovf[g]    = out_v[34];
    end

    task automatic chk(input string name, input int g, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got %0h expected %0h", name, g, act, exp);
        end
    endtask

    // Transaction model: an accepted op becomes visible at a fixed cycle number.
    int          cyc = 0;
    logic        m_active  [2];
    logic        m_owner   [2];
    logic        m_prio    [2];
    int          m_resp_at [2];
    logic [31:0] m_cur_res [2], m_prev_res [2];
    logic [3:0]  m_cur_flg [2], m_prev_flg [2];
    logic [4:0]  m_alu_op  [2], m_alu_sh [2];
    logic [31:0] m_alu_a   [2], m_alu_b  [2];

    logic [1:0]  e_rdy, e_rv;
    logic        e_show, own;
    logic [4:0]  s_op, s_sh;
    logic [31:0] s_a, s_b;
    logic [34:0] s_r;

    always @(negedge clock) begin
        cyc = cyc + 1;
        for (int g = 0; g < 2; g++) begin
            if (!reset_n) begin
                m_active[g] = 1'b0; m_prio[g] = 1'b0; m_owner[g] = 1'b0;
                m_prev_res[g] = '0; m_prev_flg[g] = '0;
                m_alu_op[g] = '0; m_alu_sh[g] = '0; m_alu_a[g] = '0; m_alu_b[g] = '0;
            end
            e_show = m_active[g] && (cyc >= m_resp_at[g]);
            if (!reset_n || m_active[g])   e_rdy = 2'b00;
            else if (req_valid[g] == 2'b11) e_rdy = m_prio[g] ? 2'b10 : 2'b01;
            else                            e_rdy = req_valid[g];
            e_rv = e_show ? (m_owner[g] ? 2'b10 : 2'b01) : 2'b00;

            chk("req_ready",  g, 64'(req_ready[g]),  64'(e_rdy));
            chk("rsp_valid",  g, 64'(rsp_valid[g]),  64'(e_rv));
            chk("busy",       g, 64'(busy[g]),       64'(m_active[g]));
            chk("rsp_result", g, 64'(rsp_result[g]), 64'(e_show ? m_cur_res[g] : m_prev_res[g]));
            chk("rsp_flags",  g, 64'(rsp_flags[g]),  64'(e_show ? m_cur_flg[g] : m_prev_flg[g]));
            chk("alu_opcode", g, 64'(alu_opcode[g]), 64'(m_alu_op[g]));
            chk("alu_a",      g, 64'(alu_a[g]),      64'(m_alu_a[g]));
            chk("alu_b",      g, 64'(alu_b[g]),      64'(m_alu_b[g]));
            chk("alu_shamt",  g, 64'(alu_shamt[g]),  64'(m_alu_sh[g]));

            if (reset_n) begin
                if (!m_active[g]) begin
                    if (e_rdy != 2'b00) begin
                        own  = e_rdy[1];
                        s_op = own ? req_opcode[g][9:5] : req_opcode[g][4:0];
                        s_sh = own ? req_shamt[g][9:5]  : req_shamt[g][4:0];
                        s_a  = own ? req_a[g][63:32] : req_a[g][31:0];
                        s_b  = own ? req_b[g][63:32] : req_b[g][31:0];
                        m_active[g] = 1'b1;
                        m_owner[g]  = own;
                        if (s_op <= OP_LAST) begin
                            m_alu_op[g] = s_op; m_alu_sh[g] = s_sh;
                            m_alu_a[g]  = s_a;  m_alu_b[g]  = s_b;
                            s_r = alu_f(s_op, s_a, s_b, s_sh);
                            m_cur_res[g] = s_r[31:0];
                            m_cur_flg[g] = {1'b0, s_r[34:32]};
                            m_resp_at[g] = cyc + 1 + lat_of(g);
                        end else begin
                            m_cur_res[g] = '0;
                            m_cur_flg[g] = 4'b1000;
                            m_resp_at[g] = cyc + 1;
                        end
                    end
                end else if (e_show && rsp_ready[g][m_owner[g]]) begin
                    m_active[g]   = 1'b0;
                    m_prio[g]     = ~m_owner[g];
                    m_prev_res[g] = m_cur_res[g];
                    m_prev_flg[g] = m_cur_flg[g];
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_idle(input int g);
        int n;
        n = 0;
        @(negedge clock);
        while (busy[g] && n < 40) begin
            @(negedge clock);
            n++;
        end
        chk("wait_idle", g, 64'(busy[g]), 64'd0);
    endtask

    task automatic wait_rsp(input int g, input logic [1:0] v);
        int n;
        n = 0;
        @(negedge clock);
        while (rsp_valid[g] !== v && n < 40) begin
            @(negedge clock);
            n++;
        end
        chk("wait_rsp", g, 64'(rsp_valid[g]), 64'(v));
    endtask

    task automatic check_all_zero(input string name, input int g);
        chk({name, "_ready"},  g, 64'(req_ready[g]),  64'd0);
        chk({name, "_rvalid"}, g, 64'(rsp_valid[g]),  64'd0);
        chk({name, "_aluop"},  g, 64'(alu_opcode[g]), 64'd0);
        chk({name, "_alua"},   g, 64'(alu_a[g]),      64'd0);
        chk({name, "_alub"},   g, 64'(alu_b[g]),      64'd0);
        chk({name, "_alush"},  g, 64'(alu_shamt[g]),  64'd0);
        chk({name, "_result"}, g, 64'(rsp_result[g]), 64'd0);
        chk({name, "_flags"},  g, 64'(rsp_flags[g]),  64'd0);
        chk({name, "_busy"},   g, 64'(busy[g]),       64'd0);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h7FFF_FFFF;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h0000_0000;
            default: return $urandom;
        endcase
    endfunction

    task automatic new_req(input int g, input int r);
        logic [4:0] op;
        op = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(7, 31)) : 5'($urandom_range(0, 6));
        req_opcode[g][r*5 +: 5]  = op;
        req_shamt[g][r*5 +: 5]   = 5'($urandom_range(0, 31));
        req_a[g][r*32 +: 32]     = pick_operand();
        req_b[g][r*32 +: 32]     = pick_operand();
        req_valid[g][r]          = ($urandom_range(0, 3) != 0);
    endtask

    logic [1:0] grants [3];
    logic [1:0] hs     [2];
    int         ng;

    initial begin
        for (int g = 0; g < 2; g++) begin
            req_valid[g] = '0; req_opcode[g] = '0; req_a[g] = '0; req_b[g] = '0;
            req_shamt[g] = '0; rsp_ready[g] = '0;
        end
        #1 reset_n = 1'b0;
        repeat (2) @(negedge clock);
        check_all_zero("reset", 0);
        check_all_zero("reset", 1);
        tick();
        reset_n = 1'b1;

        // Simultaneous requests from reset: 0, then 1, then 0.
        tick();
        req_opcode[0] = {OP_ADD, OP_ADD};
        req_a[0] = {$urandom, $urandom};
        req_b[0] = {$urandom, $urandom};
        req_valid[0] = 2'b11;
        rsp_ready[0] = 2'b11;
        ng = 0;
        for (int n = 0; n < 20 && ng < 3; n++) begin
            @(negedge clock);
            if (req_ready[0] != 2'b00) begin
                grants[ng] = req_ready[0];
                ng++;
            end
        end
        chk("rr_count",  0, 64'(ng), 64'd3);
        chk("rr_first",  0, 64'(grants[0]), 64'b01);
        chk("rr_second", 0, 64'(grants[1]), 64'b10);
        chk("rr_third",  0, 64'(grants[2]), 64'b01);
        tick();
        req_valid[0] = 2'b00;
        wait_idle(0);

        // Single NOT on requester 0.
        tick();
        req_opcode[0][4:0] = OP_NOT;
        req_a[0][31:0] = 32'h0F0F_00FF;
        req_b[0][31:0] = $urandom;
        req_shamt[0][4:0] = 5'd9;
        req_valid[0] = 2'b01;
        rsp_ready[0] = 2'b00;
        @(negedge clock);
        chk("not_accept", 0, 64'(req_ready[0]), 64'b01);
        tick();
        req_valid[0] = 2'b00;
        @(negedge clock);
        chk("not_aluop", 0, 64'(alu_opcode[0]), 64'(OP_NOT));
        chk("not_alua",  0, 64'(alu_a[0]), 64'h0F0F_00FF);
        chk("not_early", 0, 64'(rsp_valid[0]), 64'b00);
        @(negedge clock);
        chk("not_rvalid", 0, 64'(rsp_valid[0]), 64'b01);
        chk("not_result", 0, 64'(rsp_result[0]), 64'hF0F0_FF00);
        chk("not_flags",  0, 64'(rsp_flags[0]), 64'h0);
        tick();
        rsp_ready[0] = 2'b11;
        wait_idle(0);
        tick();
        rsp_ready[0] = 2'b00;

        // Backpressure on requester 1 SUB 5-7, requester 0 waiting behind it.
        req_opcode[0][9:5] = OP_SUB;
        req_a[0][63:32] = 32'd5;
        req_b[0][63:32] = 32'd7;
        req_shamt[0][9:5] = 5'd0;
        req_valid[0] = 2'b10;
        @(negedge clock);
        chk("sub_accept", 0, 64'(req_ready[0]), 64'b10);
        tick();
        req_opcode[0][4:0] = OP_OR;
        req_a[0][31:0] = 32'h1234_0000;
        req_b[0][31:0] = 32'h0000_5678;
        req_shamt[0][4:0] = 5'd3;
        req_valid[0] = 2'b01;
        wait_rsp(0, 2'b10);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clock);
            chk("bp_result", 0, 64'(rsp_result[0]), 64'hFFFF_FFFE);
            chk("bp_flags",  0, 64'(rsp_flags[0]), 64'b0011);
            chk("bp_ready",  0, 64'(req_ready[0]), 64'b00);
        end
        tick();
        rsp_ready[0] = 2'b10;
        @(negedge clock);
        tick();
        rsp_ready[0] = 2'b00;
        @(negedge clock);
        chk("or_accept", 0, 64'(req_ready[0]), 64'b01);
        tick();
        req_valid[0] = 2'b00;
        wait_rsp(0, 2'b01);
        chk("or_result", 0, 64'(rsp_result[0]), 64'h1234_5678);
        tick();
        rsp_ready[0] = 2'b01;
        wait_idle(0);

        // Illegal opcode: bypass straight to response, ALU registers untouched.
        tick();
        rsp_ready[0] = 2'b00;
        req_opcode[0][4:0] = 5'b10101;
        req_a[0][31:0] = $urandom;
        req_valid[0] = 2'b01;
        @(negedge clock);
        chk("ill_accept", 0, 64'(req_ready[0]), 64'b01);
        tick();
        req_valid[0] = 2'b00;
        @(negedge clock);
        chk("ill_rvalid", 0, 64'(rsp_valid[0]), 64'b01);
        chk("ill_result", 0, 64'(rsp_result[0]), 64'h0);
        chk("ill_flags",  0, 64'(rsp_flags[0]), 64'b1000);
        chk("ill_aluop",  0, 64'(alu_opcode[0]), 64'(OP_OR));
        chk("ill_alua",   0, 64'(alu_a[0]), 64'h1234_0000);
        tick();
        rsp_ready[0] = 2'b01;
        wait_idle(0);

        // ALU_LAT=3 instance: ADD overflow.
        tick();
        req_opcode[1][4:0] = OP_ADD;
        req_a[1][31:0] = 32'h7FFF_FFFF;
        req_b[1][31:0] = 32'h0000_0001;
        req_valid[1] = 2'b01;
        rsp_ready[1] = 2'b01;
        @(negedge clock);
        chk("lat3_accept", 1, 64'(req_ready[1]), 64'b01);
        tick();
        req_valid[1] = 2'b00;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clock);
            chk("lat3_early", 1, 64'(rsp_valid[1]), 64'b00);
        end
        @(negedge clock);
        chk("lat3_rvalid", 1, 64'(rsp_valid[1]), 64'b01);
        chk("lat3_result", 1, 64'(rsp_result[1]), 64'h8000_0000);
        chk("lat3_flags",  1, 64'(rsp_flags[1]), 64'b0100);
        wait_idle(1);

        // Reset while both instances are in EXEC.
        tick();
        rsp_ready[0] = 2'b00;
        rsp_ready[1] = 2'b00;
        req_opcode[0][4:0] = OP_ADD; req_a[0][31:0] = 32'd10; req_b[0][31:0] = 32'd20;
        req_opcode[1][4:0] = OP_SUB; req_a[1][31:0] = 32'd9;  req_b[1][31:0] = 32'd4;
        req_valid[0] = 2'b01;
        req_valid[1] = 2'b01;
        @(negedge clock);
        chk("rst_accept", 0, 64'(req_ready[0]), 64'b01);
        chk("rst_accept", 1, 64'(req_ready[1]), 64'b01);
        tick();
        req_valid[0] = 2'b00;
        req_valid[1] = 2'b00;
        #1 reset_n = 1'b0;
        #1;
        check_all_zero("rst_now", 0);
        check_all_zero("rst_now", 1);
        tick();
        reset_n = 1'b1;
        rsp_ready[0] = 2'b01;
        rsp_ready[1] = 2'b01;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            chk("rst_norsp", 0, 64'(rsp_valid[0]), 64'b00);
            chk("rst_norsp", 1, 64'(rsp_valid[1]), 64'b00);
        end
        tick();
        req_a[0][31:0] = 32'd2;
        req_b[0][31:0] = 32'd3;
        req_valid[0] = 2'b01;
        @(negedge clock);
        chk("post_accept", 0, 64'(req_ready[0]), 64'b01);
        tick();
        req_valid[0] = 2'b00;
        @(negedge clock);
        @(negedge clock);
        chk("post_rvalid", 0, 64'(rsp_valid[0]), 64'b01);
        chk("post_result", 0, 64'(rsp_result[0]), 64'd5);
        wait_idle(0);

        // Random traffic on both instances.
        for (int n = 0; n < 3000; n++) begin
            @(negedge clock);
            for (int g = 0; g < 2; g++) hs[g] = req_valid[g] & req_ready[g];
            @(posedge clock);
            #1;
            for (int g = 0; g < 2; g++) begin
                for (int r = 0; r < 2; r++) begin
                    if (!req_valid[g][r] || hs[g][r]) new_req(g, r);
                end
                rsp_ready[g] = 2'($urandom_range(0, 3));
            end
        end
        @(negedge clock);
        tick();
        for (int g = 0; g < 2; g++) begin
            req_valid[g] = 2'b00;
            rsp_ready[g] = 2'b11;
        end
        wait_idle(0);
        wait_idle(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
